// File: rtl/rx_eyeq_hs_ctrl.sv
// rx_eyeq_hs_ctrl: multi-lane RX eyeq req/done handshake controller with timeout, abort and one response per command
module rx_eyeq_hs_ctrl #(
  parameter int N_LANES     = 4,
  parameter int MODE_W      = 4,
  parameter int RES_W       = 8,
  parameter int TO_W        = 16,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [MODE_W-1:0]        cmd_mode,
  input  logic [N_LANES-1:0]       cmd_lane_mask,
  input  logic [1:0]               rxpdwn,
  output logic [N_LANES-1:0]       rxeyeqreq,
  output logic [MODE_W-1:0]        rxeyeqmode,
  input  logic [N_LANES-1:0]       rxeyeqdone,
  input  logic [N_LANES*RES_W-1:0] rxeyeq,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [1:0]               rsp_status,
  output logic [N_LANES-1:0]       rsp_done_mask,
  output logic [N_LANES*RES_W-1:0] rsp_result,
  output logic                     proto_err
);
  typedef enum logic [1:0] {IDLE, REQ, RELEASE, RSP} state_t;
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYC);
  localparam logic [1:0] ST_OK = 2'b00, ST_TO = 2'b01, ST_AB = 2'b10, ST_BAD = 2'b11;
  state_t                   state_q, state_d;
  logic [TO_W-1:0]          cnt_q, cnt_d;
  logic [N_LANES-1:0]       mask_q, mask_d, req_q, req_d, dmask_q, dmask_d, done_prev_q;
  logic [N_LANES-1:0]       new_done, rise, fall;
  logic [MODE_W-1:0]        mode_q, mode_d;
  logic [N_LANES*RES_W-1:0] res_q, res_d;
  logic [1:0]               status_q, status_d;
  logic                     rsp_valid_q, rsp_valid_d, perr_q, perr_d, cmd_ready_q, cmd_ready_d, pdwn;
  assign cmd_ready     = cmd_ready_q;
  assign rxeyeqreq     = req_q;
  assign rxeyeqmode    = mode_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_status    = status_q;
  assign rsp_done_mask = dmask_q;
  assign rsp_result    = res_q;
  assign proto_err     = perr_q;
  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    mask_d      = mask_q;
    req_d       = req_q;
    dmask_d     = dmask_q;
    mode_d      = mode_q;
    res_d       = res_q;
    status_d    = status_q;
    rsp_valid_d = rsp_valid_q;
    pdwn        = rxpdwn != 2'b00;
    new_done    = rxeyeqdone & req_q & ~dmask_q;
    rise        = rxeyeqdone & ~done_prev_q;
    fall        = done_prev_q & ~rxeyeqdone;
    case (state_q)
      IDLE: if (cmd_valid && cmd_ready_q) begin
        mask_d  = cmd_lane_mask;
        dmask_d = '0;
        res_d   = '0;
        cnt_d   = '0;
        if (cmd_lane_mask == '0) begin
          status_d    = ST_BAD;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end else begin
          mode_d   = cmd_mode;
          req_d    = cmd_lane_mask & ~rxeyeqdone;
          status_d = ST_OK;
          state_d  = REQ;
        end
      end
      REQ: begin
        dmask_d = dmask_q | new_done;
        for (int i = 0; i < N_LANES; i++)
          res_d[i*RES_W +: RES_W] = new_done[i] ? rxeyeq[i*RES_W +: RES_W] : res_q[i*RES_W +: RES_W];
        req_d = req_q | (mask_q & ~rxeyeqdone & ~dmask_d);
        if (pdwn || dmask_d == mask_q || cnt_q >= TO_LIM) begin
          req_d    = '0;
          cnt_d    = '0;
          state_d  = RELEASE;
          status_d = pdwn ? ST_AB : (dmask_d == mask_q) ? ST_OK : ST_TO;
        end
      end
      RELEASE: if ((rxeyeqdone & mask_q) == '0 || cnt_q >= TO_LIM) begin
        state_d     = RSP;
        rsp_valid_d = 1'b1;
        if ((rxeyeqdone & mask_q) != '0 && status_q != ST_AB) status_d = ST_TO;
      end
      default: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
    cmd_ready_d = (state_d == IDLE) && !pdwn && (rxeyeqdone == '0);
    // a done edge is only legal as a rise on a masked lane in REQ, or a fall once req has dropped
    perr_d = perr_q | (|(rise & ~((state_q == REQ) ? mask_q : '0))) | (|(fall & mask_q & req_q & dmask_q));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mask_q      <= '0;
      req_q       <= '0;
      dmask_q     <= '0;
      mode_q      <= '0;
      res_q       <= '0;
      status_q    <= '0;
      rsp_valid_q <= 1'b0;
      perr_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
      done_prev_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      req_q       <= req_d;
      dmask_q     <= dmask_d;
      mode_q      <= mode_d;
      res_q       <= res_d;
      status_q    <= status_d;
      rsp_valid_q <= rsp_valid_d;
      perr_q      <= perr_d;
      cmd_ready_q <= cmd_ready_d;
      done_prev_q <= rxeyeqdone;
    end
  end
endmodule

// File: tb/tb_rx_eyeq_hs_ctrl.sv
// tb_rx_eyeq_hs_ctrl: scenario tasks with a response scoreboard for rx_eyeq_hs_ctrl
module tb_rx_eyeq_hs_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [3:0]  cmd_mode = '0, cmd_lane_mask = '0;
  logic [1:0]  rxpdwn = '0;
  logic [3:0]  rxeyeqreq, rxeyeqdone = '0, rsp_done_mask;
  logic [3:0]  rxeyeqmode;
  logic [31:0] rxeyeq = '0, rsp_result;
  logic        rsp_valid, rsp_ready = 1'b0, proto_err;
  logic [1:0]  rsp_status;
  int n_tests = 0, n_fail = 0;
  typedef struct {logic [1:0] st; logic [3:0] dm; logic [31:0] res;} rsp_t;
  rsp_t sb[$];
  rsp_t e;

  rx_eyeq_hs_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_lane_mask(cmd_lane_mask), .rxpdwn(rxpdwn), .rxeyeqreq(rxeyeqreq), .rxeyeqmode(rxeyeqmode),
    .rxeyeqdone(rxeyeqdone), .rxeyeq(rxeyeq), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status), .rsp_done_mask(rsp_done_mask), .rsp_result(rsp_result), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_cmd(input logic [3:0] mode, input logic [3:0] mask, output bit ok);
    bit acc;
    ok = 1'b0;
    cmd_mode = mode;
    cmd_lane_mask = mask;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      acc = cmd_ready;
      tick();
      ok = acc;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit got);
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      if (rsp_valid) got = 1'b1;
      else tick();
    end
  endtask

  task automatic ack_rsp;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(2);
    n_tests++;
    if ({cmd_ready, rxeyeqreq, rxeyeqmode, rsp_valid, rsp_status, rsp_done_mask, rsp_result, proto_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%b mode=%b rspv=%b st=%b dm=%b res=%h perr=%b rdy=%b, want all 0",
               rxeyeqreq, rxeyeqmode, rsp_valid, rsp_status, rsp_done_mask, rsp_result, proto_err, cmd_ready);
    end
    rst_n = 1'b1;
    tick(2);
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: cmd_ready=%b want 1", cmd_ready);
    end
  endtask

  task automatic test_basic;
    bit ok, got, stable;
    sb.push_back('{2'b00, 4'b0101, 32'h000A_000A});
    send_cmd(4'b0100, 4'b0101, ok);
    n_tests++;
    if (!ok || rxeyeqreq !== 4'b0101 || rxeyeqmode !== 4'b0100) begin
      n_fail++;
      $display("FAIL basic_req: ok=%b req=%b mode=%b want req=0101 mode=0100", ok, rxeyeqreq, rxeyeqmode);
    end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rxeyeqreq !== 4'b0101 || rxeyeqmode !== 4'b0100) stable = 1'b0;
    end
    n_tests++;
    if (!stable) begin
      n_fail++;
      $display("FAIL basic_hold: req=%b mode=%b want 0101/0100 throughout", rxeyeqreq, rxeyeqmode);
    end
    rxeyeq = {4{8'd10}};
    rxeyeqdone = 4'b0101;
    tick();
    n_tests++;
    if (rxeyeqreq !== 4'b0000 || rxeyeqmode !== 4'b0100) begin
      n_fail++;
      $display("FAIL basic_release: req=%b mode=%b want 0000/0100", rxeyeqreq, rxeyeqmode);
    end
    rxeyeqdone = 4'b0000;
    wait_rsp(got);
    e = sb.pop_front();
    n_tests++;
    if (!got || rsp_status !== e.st || rsp_done_mask !== e.dm || rsp_result !== e.res) begin
      n_fail++;
      $display("FAIL basic_rsp: got v=%b st=%b dm=%b res=%h want st=%b dm=%b res=%h",
               got, rsp_status, rsp_done_mask, rsp_result, e.st, e.dm, e.res);
    end
    ack_rsp();
    n_tests++;
    if (rsp_valid !== 1'b0 || proto_err !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_ack: rsp_valid=%b proto_err=%b want 0/0", rsp_valid, proto_err);
    end
  endtask

  task automatic test_timeout;
    bit ok, got;
    int cyc;
    sb.push_back('{2'b01, 4'b0111, 32'h0033_2211});
    send_cmd(4'b0011, 4'b1111, ok);
    tick(3);
    rxeyeq = 32'h4433_2211;
    rxeyeqdone = 4'b0111;
    cyc = 4;
    while (rxeyeqreq != 4'b0000 && cyc < 1100) begin
      tick();
      cyc++;
    end
    n_tests++;
    if (!ok || cyc < 995 || cyc > 1005) begin
      n_fail++;
      $display("FAIL timeout_req_drop: req fell after %0d cycles want about 1000 (ok=%b)", cyc, ok);
    end
    rxeyeqdone = 4'b0000;
    wait_rsp(got);
    e = sb.pop_front();
    n_tests++;
    if (!got || rsp_status !== e.st || rsp_done_mask !== e.dm || rsp_result !== e.res) begin
      n_fail++;
      $display("FAIL timeout_rsp: got v=%b st=%b dm=%b res=%h want st=%b dm=%b res=%h",
               got, rsp_status, rsp_done_mask, rsp_result, e.st, e.dm, e.res);
    end
    ack_rsp();
  endtask

  task automatic test_abort;
    bit ok, got, rdy_low;
    sb.push_back('{2'b10, 4'b0000, 32'h0});
    send_cmd(4'b0001, 4'b0011, ok);
    tick(3);
    rxpdwn = 2'b01;
    tick();
    n_tests++;
    if (!ok || rxeyeqreq !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_req: ok=%b req=%b want 0000", ok, rxeyeqreq);
    end
    wait_rsp(got);
    e = sb.pop_front();
    n_tests++;
    if (!got || rsp_status !== e.st || rsp_done_mask !== e.dm || rsp_result !== e.res) begin
      n_fail++;
      $display("FAIL abort_rsp: got v=%b st=%b dm=%b res=%h want st=%b dm=%b res=%h",
               got, rsp_status, rsp_done_mask, rsp_result, e.st, e.dm, e.res);
    end
    ack_rsp();
    rdy_low = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cmd_ready !== 1'b0) rdy_low = 1'b0;
    end
    n_tests++;
    if (!rdy_low) begin
      n_fail++;
      $display("FAIL abort_ready_pdwn: cmd_ready=%b want 0 while powered down", cmd_ready);
    end
    rxpdwn = 2'b00;
    tick(2);
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_ready_back: cmd_ready=%b want 1", cmd_ready);
    end
  endtask

  task automatic test_badcmd;
    bit ok, got, quiet, stable;
    sb.push_back('{2'b11, 4'b0000, 32'h0});
    send_cmd(4'b1001, 4'b0000, ok);
    quiet = (rxeyeqreq == 4'b0000);
    wait_rsp(got);
    e = sb.pop_front();
    n_tests++;
    if (!ok || !got || rsp_status !== e.st || rsp_done_mask !== e.dm || rsp_result !== e.res) begin
      n_fail++;
      $display("FAIL badcmd_rsp: got ok=%b v=%b st=%b dm=%b res=%h want st=%b dm=%b res=%h",
               ok, got, rsp_status, rsp_done_mask, rsp_result, e.st, e.dm, e.res);
    end
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rxeyeqreq !== 4'b0000) quiet = 1'b0;
      if (rsp_valid !== 1'b1 || rsp_status !== e.st || rsp_done_mask !== e.dm || rsp_result !== e.res) stable = 1'b0;
    end
    n_tests++;
    if (!stable || !quiet) begin
      n_fail++;
      $display("FAIL badcmd_stall: stable=%b noreq=%b v=%b st=%b want 1/1 v=1 st=%b", stable, quiet, rsp_valid, rsp_status, e.st);
    end
    ack_rsp();
  endtask

  task automatic test_proto;
    bit ok, got;
    sb.push_back('{2'b00, 4'b0101, 32'h003C_005A});
    send_cmd(4'b0110, 4'b0101, ok);
    tick(2);
    rxeyeq = 32'h0000_005A;
    rxeyeqdone = 4'b0001;
    tick();
    rxeyeq = 32'h0000_00A5;
    rxeyeqdone = 4'b0011;
    tick(2);
    n_tests++;
    if (!ok || proto_err !== 1'b1) begin
      n_fail++;
      $display("FAIL proto_set: proto_err=%b ok=%b want 1", proto_err, ok);
    end
    rxeyeq = 32'h003C_00A5;
    rxeyeqdone = 4'b0101;
    tick();
    rxeyeqdone = 4'b0000;
    wait_rsp(got);
    e = sb.pop_front();
    n_tests++;
    if (!got || rsp_status !== e.st || rsp_done_mask !== e.dm || rsp_result !== e.res) begin
      n_fail++;
      $display("FAIL proto_rsp: got v=%b st=%b dm=%b res=%h want st=%b dm=%b res=%h",
               got, rsp_status, rsp_done_mask, rsp_result, e.st, e.dm, e.res);
    end
    ack_rsp();
    tick(5);
    n_tests++;
    if (proto_err !== 1'b1) begin
      n_fail++;
      $display("FAIL proto_sticky: proto_err=%b want 1", proto_err);
    end
  endtask

  task automatic test_async_reset;
    bit ok, got;
    send_cmd(4'b1010, 4'b1111, ok);
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({rxeyeqreq, rxeyeqmode, rsp_valid, rsp_status, rsp_done_mask, rsp_result, proto_err} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: req=%b mode=%b rspv=%b perr=%b want all 0", rxeyeqreq, rxeyeqmode, rsp_valid, proto_err);
    end
    tick(2);
    rst_n = 1'b1;
    tick(2);
    n_tests++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_idle: rsp_valid=%b cmd_ready=%b want 0/1", rsp_valid, cmd_ready);
    end
    sb.push_back('{2'b00, 4'b0010, 32'h0000_7700});
    send_cmd(4'b0101, 4'b0010, ok);
    tick(2);
    rxeyeq = 32'h0000_7700;
    rxeyeqdone = 4'b0010;
    tick();
    rxeyeqdone = 4'b0000;
    wait_rsp(got);
    e = sb.pop_front();
    n_tests++;
    if (!ok || !got || rsp_status !== e.st || rsp_done_mask !== e.dm || rsp_result !== e.res || proto_err !== 1'b0) begin
      n_fail++;
      $display("FAIL async_next_rsp: got ok=%b v=%b st=%b dm=%b res=%h perr=%b want st=%b dm=%b res=%h perr=0",
               ok, got, rsp_status, rsp_done_mask, rsp_result, proto_err, e.st, e.dm, e.res);
    end
    ack_rsp();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_abort();
    test_badcmd();
    test_proto();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
